// File: rtl/wb_trace_collector.sv
// Merges WB-stage register writes and MEM-stage stores into one program-ordered record FIFO.
// Optional macro TRACE_CYCLE_STAMP_EN adds a per-record capture-cycle stamp on out_cycle.
module wb_trace_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grf_we,
  input  logic [31:0]       grf_pc,
  input  logic [4:0]        grf_addr,
  input  logic [31:0]       grf_wd,
  input  logic              dm_we,
  input  logic [31:0]       dm_pc,
  input  logic [31:0]       dm_addr,
  input  logic [3:0]        dm_be,
  input  logic [31:0]       dm_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_addr,
  output logic [31:0]       out_data,
  output logic [3:0]        out_be,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [31:0]       out_cycle,
`endif
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 2;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc;
`endif
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    wr_nxt_s;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W:0]   drop_sum_s;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]      cyc_q, cyc_d;
`endif

  logic             grf_evt_s, dm_evt_s, pop_s, valid_s;
  logic [SW-1:0]    space_s;
  logic [1:0]       n_evt_s, n_acc_s, n_drop_s;
  rec_t             grf_rec_s, dm_rec_s, rec0_s, head_s;

  // Qualify incoming strobes and format them as records
  always_comb begin
    grf_evt_s      = grf_we && (grf_addr != 5'd0);
    dm_evt_s       = dm_we && (dm_be != 4'd0);
    grf_rec_s      = '0;
    grf_rec_s.kind = 1'b0;
    grf_rec_s.pc   = grf_pc;
    grf_rec_s.addr = {27'd0, grf_addr};
    grf_rec_s.data = grf_wd;
    grf_rec_s.be   = 4'hF;
    dm_rec_s       = '0;
    dm_rec_s.kind  = 1'b1;
    dm_rec_s.pc    = dm_pc;
    dm_rec_s.addr  = dm_addr;
    dm_rec_s.data  = dm_wd;
    dm_rec_s.be    = dm_be;
`ifdef TRACE_CYCLE_STAMP_EN
    grf_rec_s.cyc  = cyc_q;
    dm_rec_s.cyc   = cyc_q;
`endif
    // The WB instruction is older, so it claims the first free slot
    if (grf_evt_s) begin
      rec0_s = grf_rec_s;
    end else begin
      rec0_s = dm_rec_s;
    end
  end

  // FIFO bookkeeping: accept events in order up to free space, count the rest as drops
  always_comb begin
    mem_d      = mem_q;
    valid_s    = (count_q != {(AW+1){1'b0}});
    pop_s      = valid_s && out_ready;
    space_s    = SW'(DEPTH) - SW'(count_q) + SW'(pop_s);
    n_evt_s    = {1'b0, grf_evt_s} + {1'b0, dm_evt_s};
    if (SW'(n_evt_s) <= space_s) begin
      n_acc_s = n_evt_s;
    end else begin
      n_acc_s = space_s[1:0];
    end
    n_drop_s   = n_evt_s - n_acc_s;
    wr_nxt_s   = wr_ptr_q + AW'(1);
    if (n_acc_s != 2'd0) begin
      mem_d[wr_ptr_q] = rec0_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    if (n_acc_s == 2'd2) begin
      mem_d[wr_nxt_s] = dm_rec_s;
    end else begin
      mem_d[wr_nxt_s] = mem_d[wr_nxt_s];
    end
    wr_ptr_d   = wr_ptr_q + AW'(n_acc_s);
    rd_ptr_d   = rd_ptr_q + AW'(pop_s);
    count_d    = count_q + (AW+1)'(n_acc_s) - (AW+1)'(pop_s);
    drop_sum_s = {1'b0, drop_q} + (CNT_W+1)'(n_drop_s);
    if (drop_sum_s[CNT_W]) begin
      drop_d = {CNT_W{1'b1}};
    end else begin
      drop_d = drop_sum_s[CNT_W-1:0];
    end
    overflow_d = overflow_q | (n_drop_s != 2'd0);
`ifdef TRACE_CYCLE_STAMP_EN
    cyc_d      = cyc_q + 32'd1;
`endif
  end

  // State registers with synchronous flush
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
      drop_q     <= {CNT_W{1'b0}};
`ifdef TRACE_CYCLE_STAMP_EN
      cyc_q      <= 32'd0;
`endif
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
`ifdef TRACE_CYCLE_STAMP_EN
      cyc_q      <= cyc_d;
`endif
    end
  end

  // Head presentation; fields read as zero when nothing is buffered
  always_comb begin
    head_s    = mem_q[rd_ptr_q];
    out_valid = (count_q != {(AW+1){1'b0}});
    overflow  = overflow_q;
    drop_cnt  = drop_q;
    if (out_valid) begin
      out_kind  = head_s.kind;
      out_pc    = head_s.pc;
      out_addr  = head_s.addr;
      out_data  = head_s.data;
      out_be    = head_s.be;
`ifdef TRACE_CYCLE_STAMP_EN
      out_cycle = head_s.cyc;
`endif
    end else begin
      out_kind  = 1'b0;
      out_pc    = 32'd0;
      out_addr  = 32'd0;
      out_data  = 32'd0;
      out_be    = 4'd0;
`ifdef TRACE_CYCLE_STAMP_EN
      out_cycle = 32'd0;
`endif
    end
  end

endmodule

// File: tb/tb_wb_trace_collector.sv
// Directed bench for wb_trace_collector with a queue-based reference model and per-cycle compare.
module tb_wb_trace_collector;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wd;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic [31:0] out_cycle_w;
  logic        overflow;
  logic [CNT_W-1:0] drop_cnt;

  wb_trace_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wd(dm_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
`ifdef TRACE_CYCLE_STAMP_EN
    .out_cycle(out_cycle_w),
`endif
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

`ifndef TRACE_CYCLE_STAMP_EN
  assign out_cycle_w = 32'd0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] cyc;
  } trec_t;

  trec_t       mq[$];
  int unsigned m_drop;
  bit          m_ovf;
  logic [31:0] m_cyc;
  bit          started = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered event list, space-limited acceptance, saturating drop count
  task automatic model_step();
    trec_t ev[$];
    trec_t r;
    int    space;
    bit    pop;
    if (reset) begin
      mq.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      m_cyc  = 32'd0;
    end else begin
      pop   = (mq.size() != 0) && out_ready;
      space = DEPTH - mq.size() + (pop ? 1 : 0);
      if (pop) r = mq.pop_front();
      if (grf_we && grf_addr != 5'd0) begin
        r = '{1'b0, grf_pc, {27'd0, grf_addr}, grf_wd, 4'hF, m_cyc};
        ev.push_back(r);
      end
      if (dm_we && dm_be != 4'd0) begin
        r = '{1'b1, dm_pc, dm_addr, dm_wd, dm_be, m_cyc};
        ev.push_back(r);
      end
      foreach (ev[i]) begin
        if (space > 0) begin
          mq.push_back(ev[i]);
          space--;
        end else begin
          if (m_drop < (1 << CNT_W) - 1) m_drop++;
          m_ovf = 1'b1;
        end
      end
      m_cyc = m_cyc + 32'd1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic clr();
    grf_we = 1'b0; dm_we = 1'b0;
  endtask

  task automatic set_grf(input logic [4:0] a, input logic [31:0] pc, input logic [31:0] wd);
    grf_we = 1'b1; grf_addr = a; grf_pc = pc; grf_wd = wd;
  endtask

  task automatic set_dm(input logic [31:0] a, input logic [3:0] be, input logic [31:0] pc,
                        input logic [31:0] wd);
    dm_we = 1'b1; dm_addr = a; dm_be = be; dm_pc = pc; dm_wd = wd;
  endtask

  // Per-cycle compare of DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_cnt", 32'(drop_cnt), m_drop);
        if (mq.size() != 0) begin
          chk("kind", {31'd0, out_kind}, {31'd0, mq[0].kind});
          chk("pc", out_pc, mq[0].pc);
          chk("addr", out_addr, mq[0].addr);
          chk("data", out_data, mq[0].data);
          chk("be", {28'd0, out_be}, {28'd0, mq[0].be});
`ifdef TRACE_CYCLE_STAMP_EN
          chk("cycle", out_cycle_w, mq[0].cyc);
        end else begin
          chk("cycle_idle", out_cycle_w, 32'd0);
`endif
        end
      end
    end
  end

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    grf_we = 1'b0; grf_pc = 32'd0; grf_addr = 5'd0; grf_wd = 32'd0;
    dm_we = 1'b0; dm_pc = 32'd0; dm_addr = 32'd0; dm_be = 4'd0; dm_wd = 32'd0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    // Single GRF event, one-cycle latency
    out_ready = 1'b1;
    set_grf(5'd8, 32'h3000, 32'h1234);
    cyc(); clr();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_kind", {31'd0, out_kind}, 32'd0);
    chk("t1_addr", out_addr, 32'h8);
    chk("t1_be", {28'd0, out_be}, 32'hF);
    chk("t1_data", out_data, 32'h1234);
    cyc();
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // $0 writes and empty byte enables are discarded silently
    set_grf(5'd0, 32'h3010, 32'hDEAD);
    set_dm(32'h40, 4'd0, 32'h3014, 32'hBEEF);
    cyc(); clr(); cyc();
    chk("t2_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_drop", 32'(drop_cnt), 32'd0);
    chk("t2_ovf", {31'd0, overflow}, 32'd0);

    // Simultaneous events: GRF first, DM next
    set_grf(5'd2, 32'h3004, 32'hAAAA0002);
    set_dm(32'h10, 4'b0011, 32'h3008, 32'h00005555);
    cyc(); clr();
    chk("t3_first_kind", {31'd0, out_kind}, 32'd0);
    chk("t3_first_pc", out_pc, 32'h3004);
    cyc();
    chk("t3_second_kind", {31'd0, out_kind}, 32'd1);
    chk("t3_second_pc", out_pc, 32'h3008);
    chk("t3_second_addr", out_addr, 32'h10);
    chk("t3_second_be", {28'd0, out_be}, 32'h3);
    cyc();
    chk("t3_empty", {31'd0, out_valid}, 32'd0);

    // Overflow: 7 singles then a pair with one slot left
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) set_grf(5'(i + 1), 32'h4000 + 32'(4 * i), 32'(i));
      else set_dm(32'h100 + 32'(4 * i), 4'hF, 32'h4000 + 32'(4 * i), 32'(i));
      cyc(); clr();
    end
    set_grf(5'd20, 32'h4100, 32'h77);
    set_dm(32'h200, 4'hC, 32'h4104, 32'h88);
    cyc(); clr();
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    chk("t4_head", out_pc, 32'h4000);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_pc", out_pc, (i < 7) ? 32'h4000 + 32'(4 * i) : 32'h4100);
      cyc();
    end
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // Full FIFO with a pop accepts one event
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_grf(5'(i + 1), 32'h5000 + 32'(4 * i), 32'h50 + 32'(i));
      cyc(); clr();
    end
    out_ready = 1'b1;
    set_dm(32'h20, 4'hF, 32'h5100, 32'h99);
    cyc(); clr();
    out_ready = 1'b0;
    chk("t5_drop", 32'(drop_cnt), 32'd1);
    chk("t5_head", out_pc, 32'h5004);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t5_drain_pc", out_pc, (i < 7) ? 32'h5004 + 32'(4 * i) : 32'h5100);
      cyc();
    end
    chk("t5_empty", {31'd0, out_valid}, 32'd0);

    // Full FIFO without a pop drops both events
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_grf(5'(i + 3), 32'h6000 + 32'(4 * i), 32'h60 + 32'(i));
      cyc(); clr();
    end
    set_grf(5'd9, 32'h6100, 32'h1);
    set_dm(32'h30, 4'h1, 32'h6104, 32'h2);
    cyc(); clr();
    chk("t6_drop", 32'(drop_cnt), 32'd3);
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    out_ready = 1'b0;
    chk("t6_head", out_pc, 32'h600C);

    // Reset with 5 entries buffered
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t7_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_drop", 32'(drop_cnt), 32'd0);
    chk("t7_ovf", {31'd0, overflow}, 32'd0);
    cyc(); cyc();
    set_grf(5'd5, 32'h7000, 32'h4242);
    cyc(); clr();
    chk("t7_post_pc", out_pc, 32'h7000);
`ifdef TRACE_CYCLE_STAMP_EN
    chk("t7_stamp", out_cycle_w, 32'd2);
`endif
    out_ready = 1'b1;
    cyc(); cyc();
    chk("t7_empty", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_collector.md
# wb_trace_collector

Synthesizable collector for the architectural side effects of the pipelined MIPS CPU. It captures register-file writes from the WB stage and data-memory writes from the MEM stage, and merges them into one stream in program order. It buffers the stream in a FIFO and hands records out over a valid/ready handshake. It is the consuming end of the CPU's write trace, feeding checkers, loggers, or a UART dumper in place of simulation-only print statements.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of drop counter

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- grf_we  in  1  WB-stage register write strobe
- grf_pc  in  32  PC of writing instruction
- grf_addr  in  5  destination register
- grf_wd  in  32  write data
- dm_we  in  1  MEM-stage store strobe
- dm_pc  in  32  PC of store
- dm_addr  in  32  word-aligned byte address
- dm_be  in  4  byte enables
- dm_wd  in  32  store data (lane-aligned)
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head
- out_kind  out  1  0 = GRF record, 1 = DM record
- out_pc  out  32  record PC
- out_addr  out  32  GRF: {27'b0, reg}; DM: address
- out_data  out  32  record data
- out_be  out  4  GRF: 4'b1111; DM: byte enables
- overflow  out  1  sticky; set on first dropped event
- drop_cnt  out  CNT_W  dropped events, saturating

## Operation
- Event qualification:
  - A GRF event is grf_we=1 with grf_addr≠0. Writes to $0 are discarded and not counted as drops.
  - A DM event is dm_we=1 with dm_be≠0. Events with dm_be=0 are discarded silently.
- Ordering: the WB instruction is older than the MEM instruction. When both events occur in the same cycle, the GRF record is pushed first and the DM record second.
- FIFO: circular buffer with rd_ptr, wr_ptr, and count (log2(DEPTH)+1 bits). Up to two pushes and one pop per cycle. Pointers wrap modulo DEPTH.
- Pop: occurs when out_valid && out_ready.
- Free space in a cycle: space = DEPTH − count + pop.
  - Qualified events are accepted in order while space remains.
  - Any remaining events are dropped. Each drop increments drop_cnt by 1, saturating at all-ones, and sets overflow.
  - With one free slot and two events, the GRF event is kept and the DM event is dropped.
- out_valid = (count≠0). The out_* fields present the head entry, read combinationally from storage.
- The head holds stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, all out_* fields=0, overflow=0, drop_cnt=0, pointers=0, count=0.
- Latency: an event sampled on edge N appears on out_* immediately after edge N when the FIFO was empty (one cycle, no combinational input-to-output path).
- Throughput: sustained one record per cycle out; two records per cycle in are absorbed up to the free space.
- Full FIFO with out_ready=1: the pop frees one slot in the same cycle, so one event is accepted.
- Empty FIFO with a push and out_ready=1: no bypass; the pushed record becomes visible on the next cycle.
- Reset mid-stream: the FIFO flushes. Buffered records are lost and are not counted as drops.
- overflow and drop_cnt clear only on reset.

## Configuration
- Macro: TRACE_CYCLE_STAMP_EN.
- When defined:
  - Adds output port out_cycle [31:0] and a 32-bit free-running cycle counter. The counter is 0 in the cycle reset deasserts, increments each clk, and wraps.
  - Each record stores the counter value of its capture cycle. Both records pushed in the same cycle carry the same stamp.
  - out_cycle is 0 while out_valid=0.
- When undefined: no counter, no stamp storage, no out_cycle port. All other behaviour is identical.

## Test plan
- Single GRF event: grf_we=1, addr=8, wd=0x1234, pc=0x3000, out_ready=1 → next cycle out_valid=1, kind=0, addr=0x8, be=4'hF, data=0x1234; following cycle out_valid=0.
- $0 filter: grf_we=1, addr=0 → out_valid stays 0, drop_cnt=0, overflow=0.
- Simultaneous events: GRF (addr=2, pc=0x3004) and DM (addr=0x10, be=4'b0011, pc=0x3008) in one cycle, out_ready=1 → GRF record first, DM record on the next cycle.
- Overflow: DEPTH=8, out_ready=0. Push 7 single events, then one cycle with both GRF and DM → GRF stored, count=8, drop_cnt=1, overflow=1. Then raise out_ready → 8 records drained in order.
- Full with pop: FIFO full, out_ready=1, one DM event → accepted, count stays 8, drop_cnt unchanged.
- Reset mid-stream: 5 entries buffered, assert reset one cycle → out_valid=0, count=0, drop_cnt=0. With TRACE_CYCLE_STAMP_EN defined, the first event after reset carries out_cycle equal to its capture-cycle count from 0.
